// File: rtl/spi_prog_sequencer.sv
// spi_prog_sequencer: streams words into on-chip memory through a byte-level
// SPI master. Each byte goes out as one spi_start pulse and the sequencer
// waits for spi_done before launching the next one.
module spi_prog_sequencer #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int          CNT_W    = 16,
   parameter logic [7:0]  CMD_ADDR = 8'h01,
   parameter logic [7:0]  CMD_DATA = 8'h02,
   parameter int          ADDR_INC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [CNT_W-1:0]  cfg_word_cnt,
   input  logic              cfg_burst,
   input  logic              abort,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              spi_start,
   output logic [7:0]        spi_data,
   input  logic              spi_done,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  words_sent,
   output logic [ADDR_W-1:0] cur_addr
);

   localparam int AB = ADDR_W / 8;
   localparam int DB = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD_A, S_ADDR, S_CMD_D, S_WAIT_WORD, S_DATA, S_NEXT, S_FIN
   } state_t;

   state_t              state, state_n, nxt;
   logic [7:0]          byte_idx;
   logic                pending;      // one byte launched, spi_done not yet seen
   logic                abort_q;      // abort seen earlier in this run
   logic [CNT_W-1:0]    word_cnt_q;
   logic                burst_q;
   logic [DATA_W-1:0]   word_q;
   logic [CNT_W-1:0]    ws_inc;
   logic [7:0]          addr_byte, data_byte, tx_byte;
   logic                sending, last_byte, launch, byte_done;
   logic                capture, accept, step, stop;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic, byte handshake and combinational outputs
   always_comb begin
      state_n   = state;
      nxt       = state;
      spi_start = 1'b0;
      spi_data  = '0;
      wr_ready  = 1'b0;
      sending   = 1'b0;
      last_byte = 1'b0;
      tx_byte   = '0;
      launch    = 1'b0;
      byte_done = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      addr_byte = '0;
      data_byte = '0;
      ws_inc    = words_sent + CNT_W'(1);
      stop      = abort | abort_q;
      for (int i = 0; i < AB; i++)
         if (byte_idx == 8'(i)) addr_byte = cur_addr[ADDR_W-1-8*i -: 8];
      for (int i = 0; i < DB; i++)
         if (byte_idx == 8'(i)) data_byte = word_q[DATA_W-1-8*i -: 8];

      case (state)
         S_IDLE: begin
            if (cfg_start) begin
               capture = 1'b1;
               state_n = (cfg_word_cnt == '0) ? S_FIN : S_CMD_A;
            end
         end
         S_CMD_A: begin
            sending = 1'b1; tx_byte = CMD_ADDR; last_byte = 1'b1; nxt = S_ADDR;
         end
         S_ADDR: begin
            sending = 1'b1; tx_byte = addr_byte; nxt = S_WAIT_WORD;
            last_byte = (byte_idx == 8'(AB-1));
         end
         S_CMD_D: begin
            sending = 1'b1; tx_byte = CMD_DATA; last_byte = 1'b1; nxt = S_DATA;
         end
         S_DATA: begin
            sending = 1'b1; tx_byte = data_byte; nxt = S_NEXT;
            last_byte = (byte_idx == 8'(DB-1));
         end
         S_WAIT_WORD: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               accept  = 1'b1;
               state_n = stop ? S_FIN : S_CMD_D;
            end else if (stop) begin
               state_n = S_FIN;
            end
         end
         S_NEXT: begin
            step = 1'b1;
            if (ws_inc == word_cnt_q || stop) state_n = S_FIN;
            else if (burst_q)                 state_n = S_WAIT_WORD;
            else                              state_n = S_CMD_A;
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Shared byte handshake for every send state
      if (sending) begin
         spi_data  = tx_byte;
         spi_start = !pending;
         launch    = !pending;
         if (pending && spi_done) begin
            byte_done = 1'b1;
            if (stop)           state_n = S_FIN;
            else if (last_byte) state_n = nxt;
         end
      end
   end

   // Datapath: run configuration, byte index, counters and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx   <= '0;
         pending    <= 1'b0;
         abort_q    <= 1'b0;
         word_cnt_q <= '0;
         burst_q    <= 1'b0;
         word_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         words_sent <= '0;
         cur_addr   <= '0;
      end else begin
         busy <= (state_n != S_IDLE);
         done <= (state == S_FIN);
         if (launch)         pending <= 1'b1;
         else if (byte_done) pending <= 1'b0;
         if (capture)        byte_idx <= '0;
         else if (byte_done) byte_idx <= last_byte ? 8'd0 : byte_idx + 8'd1;
         if (capture) begin
            word_cnt_q <= cfg_word_cnt;
            burst_q    <= cfg_burst;
            cur_addr   <= cfg_base_addr;
            words_sent <= '0;
            aborted    <= 1'b0;
            abort_q    <= 1'b0;
         end else begin
            if (abort && state != S_IDLE && state != S_FIN) abort_q <= 1'b1;
            if (state == S_FIN) aborted <= abort_q;
            if (step) begin
               words_sent <= ws_inc;
               cur_addr   <= cur_addr + ADDR_W'(ADDR_INC);
            end
         end
         if (accept) word_q <= wr_data;
      end
   end

endmodule

// File: tb/tb_spi_prog_sequencer.sv
// Bench for spi_prog_sequencer: an expected-byte queue built from the frame
// rules, a spi_master responder, a word feeder and a per-cycle compare process.
module tb_spi_prog_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [15:0] cfg_word_cnt = '0;
   logic        cfg_burst = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic        spi_start;
   logic [7:0]  spi_data;
   logic        spi_done = 1'b0;
   logic        busy, done, aborted;
   logic [15:0] words_sent;
   logic [31:0] cur_addr;

   spi_prog_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .cfg_word_cnt(cfg_word_cnt), .cfg_burst(cfg_burst), .abort(abort),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done),
      .busy(busy), .done(done), .aborted(aborted),
      .words_sent(words_sent), .cur_addr(cur_addr)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] b; bit dcmd; } ent_t;
   ent_t        q[$];          // bytes still expected on the SPI side
   logic [31:0] words[8];
   int          n_pass = 0, n_tot = 0;
   int          hs_cnt = 0, dcmd_pop = 0, start_cnt = 0, nwords = 0;
   bit          hold = 0, outst = 0, done_d = 0;
   ent_t        ce;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Expected SPI byte stream of a run, straight from the frame rules
   task automatic build(input logic [31:0] base, input int n, input bit burst);
      logic [31:0] a;
      ent_t e;
      q.delete();
      for (int i = 0; i < n; i++) begin
         a = base + 32'(i) * 32'd4;
         if (!burst || i == 0) begin
            e.b = 8'h01; e.dcmd = 0; q.push_back(e);
            for (int k = 3; k >= 0; k--) begin e.b = a[8*k +: 8]; e.dcmd = 0; q.push_back(e); end
         end
         e.b = 8'h02; e.dcmd = 1; q.push_back(e);
         for (int k = 3; k >= 0; k--) begin e.b = words[i][8*k +: 8]; e.dcmd = 0; q.push_back(e); end
      end
   endtask

   // spi_master stand-in: spi_done two cycles after each spi_start
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && spi_start) begin
            repeat (2) @(posedge clk);
            #1 spi_done = 1'b1;
            @(posedge clk);
            #1 spi_done = 1'b0;
         end
      end
   end

   // Word source; hold withholds wr_valid
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!hold && hs_cnt < nwords) begin wr_valid = 1'b1; wr_data = words[hs_cnt]; end
         else begin wr_valid = 1'b0; wr_data = '0; end
      end
   end

   // Per-cycle compare against the expected stream
   always @(negedge clk) begin
      if (!rst_n) begin
         outst  = 0;
         done_d = 0;
      end else begin
         if (done_d) outst = 0;
         done_d = spi_done;
         if (wr_ready)
            chk("wr_ready_legal", {63'd0, busy && !outst && q.size() > 0 && q[0].dcmd && hs_cnt == dcmd_pop}, 64'd1);
         if (wr_valid && wr_ready) hs_cnt++;
         if (spi_start) begin
            start_cnt++;
            chk("one_outstanding", {63'd0, outst}, 64'd0);
            chk("start_while_busy", {63'd0, busy}, 64'd1);
            chk("start_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
               ce = q.pop_front();
               chk("spi_byte", {56'd0, spi_data}, {56'd0, ce.b});
               if (ce.dcmd) dcmd_pop++;
            end
            outst = 1;
         end
         if (done) chk("done_not_busy", {63'd0, busy}, 64'd0);
      end
   end

   task automatic launch(input logic [31:0] base, input int n, input bit burst);
      @(negedge clk); #2;
      hs_cnt = 0; dcmd_pop = 0; nwords = n;
      build(base, n, burst);
      cfg_base_addr = base; cfg_word_cnt = 16'(n); cfg_burst = burst; cfg_start = 1'b1;
   endtask

   task automatic end_start();
      @(negedge clk); #2 cfg_start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input logic [15:0] ws, input logic [31:0] ad, input bit ab);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk({nm, "_done"}, {63'd0, done}, 64'd1);
      chk({nm, "_words_sent"}, {48'd0, words_sent}, {48'd0, ws});
      chk({nm, "_cur_addr"}, {32'd0, cur_addr}, {32'd0, ad});
      chk({nm, "_aborted"}, {63'd0, aborted}, {63'd0, ab});
      chk({nm, "_bytes_left"}, 64'(q.size()), 64'd0);
      nwords = 0;
   endtask

   logic [7:0] exp1 [20] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                             8'h01, 8'h10, 8'h00, 8'h00, 8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13};

   initial begin
      int s0;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {59'd0, spi_start, wr_ready, busy, done, aborted}, 64'd0);
      chk("rst_spi_data", {56'd0, spi_data}, 64'd0);
      chk("rst_counters", {16'd0, words_sent, cur_addr}, 64'd0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // non-burst, two words: model pinned to the hand-written stream
      words[0] = 32'hDEADBEEF; words[1] = 32'h00000013;
      build(32'h1000_0000, 2, 0);
      chk("t1_len", 64'(q.size()), 64'd20);
      for (int i = 0; i < 20; i++) chk("t1_literal", {56'd0, q[i].b}, {56'd0, exp1[i]});
      launch(32'h1000_0000, 2, 0); end_start();
      wait_done("t1", 16'd2, 32'h1000_0008, 0);

      // burst, three words: one address frame
      words[0] = 32'h11223344; words[1] = 32'hA5A5A5A5; words[2] = 32'h00000001;
      build(32'h1000_4000, 3, 1);
      chk("t2_len", 64'(q.size()), 64'd20);
      chk("t2_addr_frame", {24'd0, q[0].b, q[1].b, q[2].b, q[3].b, q[4].b}, 64'h01_1000_4000);
      chk("t2_dcmds", {40'd0, q[5].b, q[10].b, q[15].b}, 64'h020202);
      launch(32'h1000_4000, 3, 1); end_start();
      wait_done("t2", 16'd3, 32'h1000_400C, 0);

      // zero words: done two cycles after start, no SPI traffic
      s0 = start_cnt;
      launch(32'h5555_0000, 0, 0);
      @(negedge clk);
      chk("t3_busy_1", {62'd0, busy, done}, 64'b10);
      #2 cfg_start = 1'b0;
      @(negedge clk);
      chk("t3_done_2", {62'd0, busy, done}, 64'b01);
      @(negedge clk);
      chk("t3_idle", {62'd0, busy, done}, 64'b00);
      chk("t3_no_spi", 64'(start_cnt - s0), 64'd0);
      chk("t3_words_sent", {48'd0, words_sent}, 64'd0);

      // address wrap
      words[0] = 32'h0000_00AA; words[1] = 32'h0000_00BB;
      build(32'hFFFF_FFFC, 2, 0);
      chk("t4_first_addr", {32'd0, q[1].b, q[2].b, q[3].b, q[4].b}, 64'hFFFF_FFFC);
      chk("t4_wrap_addr", {24'd0, q[10].b, q[11].b, q[12].b, q[13].b, q[14].b}, 64'h01_0000_0000);
      launch(32'hFFFF_FFFC, 2, 0); end_start();
      wait_done("t4", 16'd2, 32'h0000_0004, 0);

      // stall: word withheld 50 cycles after the address frame
      words[0] = 32'hCAFE_F00D;
      hold = 1;
      launch(32'h0000_0100, 1, 0); end_start();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (wr_ready) break;
      end
      chk("t5_wr_ready", {63'd0, wr_ready}, 64'd1);
      s0 = start_cnt;
      repeat (50) @(negedge clk);
      chk("t5_no_spi_stall", 64'(start_cnt - s0), 64'd0);
      chk("t5_still_ready", {63'd0, wr_ready}, 64'd1);
      chk("t5_next_is_dcmd", {56'd0, q[0].b}, 64'h02);
      #1 hold = 0;
      wait_done("t5", 16'd1, 32'h0000_0104, 0);

      // abort during second data byte of the first word
      words[0] = 32'h0102_0304; words[1] = 32'h1; words[2] = 32'h2; words[3] = 32'h3;
      launch(32'h2000_0000, 4, 0);
      while (q.size() > 8) void'(q.pop_back());
      end_start();
      for (int k = 0; k < 500; k++) begin
         @(negedge clk); #1;
         if (q.size() == 0) break;
      end
      chk("t6_reached_byte", 64'(q.size()), 64'd0);
      abort = 1'b1;
      wait_done("t6", 16'd0, 32'h2000_0000, 1);
      #2 abort = 1'b0;
      s0 = start_cnt;
      repeat (10) @(negedge clk);
      chk("t6_quiet", 64'(start_cnt - s0), 64'd0);

      // reset in the middle of a byte, then a clean run
      words[0] = 32'h7777_8888; words[1] = 32'h9999_AAAA;
      s0 = start_cnt;
      launch(32'h3000_0000, 2, 1); end_start();
      for (int k = 0; k < 500; k++) begin
         @(negedge clk); #1;
         if (start_cnt >= s0 + 3) break;
      end
      rst_n = 1'b0;
      #1;
      chk("t7_rst_ctrl", {59'd0, spi_start, wr_ready, busy, done, aborted}, 64'd0);
      chk("t7_rst_data", {8'd0, spi_data, words_sent, cur_addr}, 64'd0);
      nwords = 0;
      q.delete();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      words[0] = 32'h0BAD_C0DE;
      launch(32'h0000_0040, 1, 1); end_start();
      wait_done("t7", 16'd1, 32'h0000_0044, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
